// File: rtl/tetris_field_engine.sv
// Playfield engine for the LED-matrix Tetris game: holds the locked-block
// bitmap and runs collision check, lock, line clear and level bookkeeping
// as a command/response FSM, plus a registered row readout for the display.
module tetris_field_engine #(
  parameter int COLS            = 8,
  parameter int ROWS            = 8,
  parameter int LINES_PER_LEVEL = 3,
  parameter int MAX_LEVEL       = 9,
  parameter int LEVEL_W         = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [15:0]        piece_mask,
  input  logic [5:0]         piece_x,
  input  logic [5:0]         piece_y,
  output logic               rsp_valid,
  output logic               rsp_hit,
  output logic [2:0]         lines_cleared,
  output logic [LEVEL_W-1:0] level,
  output logic               level_up,
  output logic               game_over,
  input  logic [3:0]         rd_row,
  output logic [COLS-1:0]    rd_data
);

  typedef enum logic [2:0] {IDLE, CHK, WRITE, SCAN, CLR, RSP} state_t;
  typedef logic [ROWS-1:0][COLS-1:0] field_t;

  state_t             state_q, state_d;
  field_t             field_q, field_d;
  logic [15:0]        mask_q, mask_d;
  logic [5:0]         x_q, x_d, y_q, y_d;
  logic               lock_q, lock_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [4:0]         ptr_q, ptr_d;
  logic               hit_q, hit_d;
  logic [2:0]         lines_q, lines_d;
  logic [7:0]         lineCnt_q, lineCnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               lvlUp_q, lvlUp_d;
  logic               gameOver_q, gameOver_d;
  logic [COLS-1:0]    rdData_q;

  logic [6:0]      chkRow, wrRow;
  logic [3:0]      chkNib, wrNib;
  logic [COLS-1:0] wrBits, scanRow;
  logic            rowHit, overTop;
  field_t          writeField, shiftField, downField;

  // Field columns covered by one 4-cell mask row placed at signed column px.
  function automatic logic [COLS-1:0] pieceRow(input logic [3:0] nib, input logic [5:0] px);
    logic [6:0] col;
    pieceRow = '0;
    for (int c = 0; c < 4; c++) begin
      col = {px[5], px} + 7'(c);
      for (int fc = 0; fc < COLS; fc++)
        if (nib[c] && (col == 7'(fc))) pieceRow[fc] = 1'b1;
    end
  endfunction

  // An occupied cell left of column 0 reads as a huge unsigned value, so a
  // single unsigned compare catches both side walls.
  function automatic logic colOut(input logic [3:0] nib, input logic [5:0] px);
    logic [6:0] col;
    colOut = 1'b0;
    for (int c = 0; c < 4; c++) begin
      col = {px[5], px} + 7'(c);
      if (nib[c] && (col >= 7'(COLS))) colOut = 1'b1;
    end
  endfunction

  // Row lookup that yields an empty row for anything outside the field.
  function automatic logic [COLS-1:0] rowAt(input field_t f, input logic [6:0] rs);
    rowAt = '0;
    for (int r = 0; r < ROWS; r++)
      if (rs == 7'(r)) rowAt = f[r];
  endfunction

  assign downField = {{COLS{1'b0}}, field_q[ROWS-1:1]};

  // Datapath helpers: per-row collision, full-piece write image and row shift.
  always_comb begin
    chkRow = {y_q[5], y_q} + {5'd0, cnt_q};
    chkNib = mask_q[{cnt_q, 2'b00} +: 4];
    rowHit = ((|chkNib) && chkRow[6]) || colOut(chkNib, x_q) ||
             (|(pieceRow(chkNib, x_q) & rowAt(field_q, chkRow)));
    writeField = field_q;
    overTop    = 1'b0;
    wrRow      = '0;
    wrNib      = '0;
    wrBits     = '0;
    for (int r = 0; r < 4; r++) begin
      wrRow  = {y_q[5], y_q} + 7'(r);
      wrNib  = mask_q[r*4 +: 4];
      wrBits = pieceRow(wrNib, x_q);
      for (int fr = 0; fr < ROWS; fr++)
        if (wrRow == 7'(fr)) writeField[fr] = writeField[fr] | wrBits;
      if ((|wrNib) && !wrRow[6] && (wrRow >= 7'(ROWS))) overTop = 1'b1;
    end
    scanRow    = rowAt(field_q, {2'b00, ptr_q});
    shiftField = field_q;
    for (int k = 0; k < ROWS; k++)
      if (5'(k) >= ptr_q) shiftField[k] = downField[k];
  end

  // Command FSM: accept, check rows, write, scan/clear, respond.
  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    mask_d     = mask_q;
    x_d        = x_q;
    y_d        = y_q;
    lock_d     = lock_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    hit_d      = hit_q;
    lines_d    = lines_q;
    lineCnt_d  = lineCnt_q;
    level_d    = level_q;
    lvlUp_d    = lvlUp_q;
    gameOver_d = gameOver_q;
    case (state_q)
      IDLE, RSP: begin
        if (state_q == RSP) state_d = IDLE;
        if (cmd_valid) begin
          mask_d  = piece_mask;
          x_d     = piece_x;
          y_d     = piece_y;
          lock_d  = (cmd_op == 2'd1);
          cnt_d   = '0;
          ptr_d   = '0;
          hit_d   = 1'b0;
          lines_d = '0;
          lvlUp_d = 1'b0;
          state_d = (cmd_op == 2'd2) ? CLR : CHK;
        end
      end
      CHK: begin
        hit_d = hit_q | rowHit;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (lock_q && !(hit_q || rowHit) && !gameOver_q) begin
            state_d = WRITE;
          end else begin
            if (lock_q) hit_d = 1'b1;
            state_d = RSP;
          end
        end
      end
      WRITE: begin
        field_d = writeField;
        if (overTop) gameOver_d = 1'b1;
        ptr_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (&scanRow) begin
          field_d = shiftField;
          lines_d = lines_q + 3'd1;
          if (lineCnt_q == 8'(LINES_PER_LEVEL - 1)) begin
            lineCnt_d = '0;
            if (level_q < LEVEL_W'(MAX_LEVEL)) begin
              level_d = level_q + 1'b1;
              lvlUp_d = 1'b1;
            end
          end else begin
            lineCnt_d = lineCnt_q + 8'd1;
          end
        end else if (ptr_q == 5'(ROWS - 1)) begin
          state_d = RSP;
        end else begin
          ptr_d = ptr_q + 5'd1;
        end
      end
      CLR: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd1) begin
          field_d    = '0;
          gameOver_d = 1'b0;
          level_d    = '0;
          lineCnt_d  = '0;
          state_d    = RSP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wipes the field and aborts any command in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      field_q    <= '0;
      mask_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      hit_q      <= 1'b0;
      lines_q    <= '0;
      lineCnt_q  <= '0;
      level_q    <= '0;
      lvlUp_q    <= 1'b0;
      gameOver_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      field_q    <= field_d;
      mask_q     <= mask_d;
      x_q        <= x_d;
      y_q        <= y_d;
      lock_q     <= lock_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      hit_q      <= hit_d;
      lines_q    <= lines_d;
      lineCnt_q  <= lineCnt_d;
      level_q    <= level_d;
      lvlUp_q    <= lvlUp_d;
      gameOver_q <= gameOver_d;
    end
  end

  // Registered display readout; rows beyond the field read as empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rdData_q <= '0;
    else     rdData_q <= rowAt(field_q, {3'b000, rd_row});
  end

  assign cmd_ready     = (state_q == IDLE) || (state_q == RSP);
  assign rsp_valid     = (state_q == RSP);
  assign rsp_hit       = rsp_valid & hit_q;
  assign lines_cleared = rsp_valid ? lines_q : 3'd0;
  assign level_up      = rsp_valid & lvlUp_q;
  assign level         = level_q;
  assign game_over     = gameOver_q;
  assign rd_data       = rdData_q;

endmodule
